clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl_if.sv | 26 ++
 rtl/clk_div_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// Bundle of configuration, control and status signals for clk_div_ctrl.
// The master drives the ratio/start/stop requests; the slave is the divider.
interface clk_div_ctrl_if #(
  parameter int unsigned W = 5
);
  logic         cfg_valid;
  logic [W-1:0] cfg_ratio;
  logic         cfg_ready;
  logic         start;
  logic         stop;
  logic         tick;
  logic         phase_out;
  logic         busy;
  logic [W-1:0] cur_ratio;
  logic         err;

  modport master (
    output cfg_valid, cfg_ratio, start, stop,
    input  cfg_ready, tick, phase_out, busy, cur_ratio, err
  );

  modport slave (
    input  cfg_valid, cfg_ratio, start, stop,
    output cfg_ready, tick, phase_out, busy, cur_ratio, err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: produces a tick per period and a square wave,
// with ratio changes deferred to period boundaries while running.
module clk_div_ctrl #(
  parameter int unsigned W           = 5,
  parameter int unsigned RESET_RATIO = 9
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cur_ratio_q;
  logic [W-1:0] pend_ratio_q;
  logic         pend_v_q;
  logic         err_q;

  logic busy;
  logic boundary;
  logic xfer;
  logic legal;

  assign busy     = (state_q != IDLE);
  assign boundary = busy && (cnt_q == cur_ratio_q - W'(1));
  assign xfer     = bus.cfg_valid && !pend_v_q;
  assign legal    = (bus.cfg_ratio >= W'(2));

  assign bus.cfg_ready = !pend_v_q;
  assign bus.busy      = busy;
  assign bus.tick      = busy && (cnt_q == '0);
  assign bus.phase_out = busy && (cnt_q < (cur_ratio_q >> 1));
  assign bus.cur_ratio = cur_ratio_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_ratio_q  <= W'(RESET_RATIO);
      pend_ratio_q <= '0;
      pend_v_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (xfer && !legal)
        err_q <= 1'b1;

      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (xfer && legal)
          cur_ratio_q <= bus.cfg_ratio;
        if (bus.start)
          state_q <= RUN;
      end else begin
        if (boundary) begin
          cnt_q <= '0;
          if (pend_v_q) begin
            cur_ratio_q <= pend_ratio_q;
            pend_v_q    <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + W'(1);
        end

        // xfer implies pend_v_q==0, so this never collides with the clear above;
        // a value accepted in the boundary cycle waits for the next boundary.
        if (xfer && legal) begin
          pend_ratio_q <= bus.cfg_ratio;
          pend_v_q     <= 1'b1;
        end

        if (state_q == RUN) begin
          if (bus.stop)
            state_q <= boundary ? IDLE : STOPPING;
        end else if (boundary) begin
          state_q <= IDLE;
        end
      end
    end
  end

endmodule
